// File: rtl/nn_seq_pkg.sv
// Shared types for the layer sequencer: layer state encoding, buffer
// occupancy and the ping-pong bank pointer convention.
package nn_seq_pkg;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_START   = 4'd1,
    ST_BUSY    = 4'd2,
    ST_DONE    = 4'd3,
    ST_TIMEOUT = 4'd4
  } layer_state_e;

  // Frames held in one two-bank activation buffer: 0, 1 or 2.
  typedef logic [1:0] occ_t;
  localparam occ_t OCC_EMPTY = 2'd0;
  localparam occ_t OCC_FULL  = 2'd2;

  // A bank pointer selects one half of a ping-pong buffer; every pointer
  // starts on bank A and toggles once per frame written or consumed.
  typedef logic bank_t;
  localparam bank_t BANK_A = 1'b0;

endpackage

// File: rtl/nn_layer_ctrl.sv
// Per-layer launch/completion FSM with BUSY timeout and the bank selects
// captured for the frame in flight.
module nn_layer_ctrl
  import nn_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 24'hFFFFFF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       launch_ok,
  input  logic       layer_done,
  input  bank_t      rd_bank,
  input  bank_t      wr_bank,
  output logic       ready,
  output logic [3:0] state,
  output logic       completed,
  output logic       idle,
  output logic       timed_out,
  output bank_t      in_bank,
  output bank_t      out_bank
);

  localparam int unsigned TO_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  layer_state_e    state_q, state_d;
  logic [TO_W-1:0] to_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      to_cnt   <= '0;
      in_bank  <= BANK_A;
      out_bank <= BANK_A;
    end else begin
      state_q <= state_d;
      if (state_q == ST_START)
        to_cnt <= '0;
      else if (state_q == ST_BUSY)
        to_cnt <= to_cnt + TO_W'(1);
      if (state_q == ST_IDLE && launch_ok) begin
        in_bank  <= rd_bank;
        out_bank <= wr_bank;
      end
    end
  end

  // BUSY lasts at most TIMEOUT_CYCLES cycles; a done on the last one still wins.
  always_comb begin
    state_d   = state_q;
    completed = 1'b0;
    case (state_q)
      ST_IDLE:    if (launch_ok) state_d = ST_START;
      ST_START:   state_d = ST_BUSY;
      ST_BUSY: begin
        if (layer_done) begin
          state_d   = ST_DONE;
          completed = 1'b1;
        end else if (to_cnt == TO_LAST) begin
          state_d = ST_TIMEOUT;
        end
      end
      ST_DONE:    state_d = ST_IDLE;
      ST_TIMEOUT: state_d = ST_TIMEOUT;
      default:    state_d = ST_IDLE;
    endcase
  end

  assign ready     = (state_q == ST_START);
  assign idle      = (state_q == ST_IDLE);
  assign timed_out = (state_q == ST_TIMEOUT);
  assign state     = state_q;

endmodule

// File: rtl/nn_layer_sequencer.sv
// Sequences NUM_LAYERS layer engines through a chain of ping-pong activation
// buffers, sequentially or pipelined, with timeout flags and a frame counter.
module nn_layer_sequencer
  import nn_seq_pkg::*;
#(
  parameter int unsigned NUM_LAYERS     = 3,
  parameter int unsigned DONE_W         = 7,
  parameter int unsigned STATE_W        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 2**24 - 1,
  parameter int unsigned CNT_W          = 16
) (
  input  logic                          clk_clk,
  input  logic                          reset_reset_n,
  input  logic                          mode_pipelined,
  input  logic                          start_valid,
  output logic                          start_ready,
  output logic                          hps_wr_bank,
  output logic [NUM_LAYERS-1:0]         layer_ready,
  input  logic [NUM_LAYERS-1:0]         layer_done,
  output logic [NUM_LAYERS-1:0]         layer_in_bank,
  output logic [NUM_LAYERS-1:0]         layer_out_bank,
  output logic [NUM_LAYERS*STATE_W-1:0] layer_state,
  input  logic [DONE_W-1:0]             result_code,
  output logic                          result_valid,
  output logic [DONE_W-1:0]             result_data,
  input  logic                          result_ack,
  output logic [NUM_LAYERS-1:0]         timeout_err,
  output logic                          busy,
  output logic [CNT_W-1:0]              frame_count
);

  localparam int unsigned LAST = NUM_LAYERS - 1;

  occ_t  occ    [NUM_LAYERS];
  bank_t wr_ptr [NUM_LAYERS];
  bank_t rd_ptr [NUM_LAYERS];

  logic [NUM_LAYERS-1:0] inc, dec, cand, launch, idle, completed;
  logic [3:0]            st [NUM_LAYERS];
  logic                  mode_q, any_occ, any_active, handshake;

  always_comb begin
    any_occ = 1'b0;
    for (int unsigned b = 0; b < NUM_LAYERS; b++)
      any_occ = any_occ | (occ[b] != OCC_EMPTY);
  end

  assign any_active  = ~&idle;
  assign busy        = any_occ | any_active | result_valid;
  assign start_ready = mode_q ? (occ[0] < OCC_FULL) : !busy;
  assign handshake   = start_valid && start_ready;
  assign hps_wr_bank = wr_ptr[0];

  // Buffer b is written by layer b-1 (the HPS for b=0) and read by layer b.
  assign inc = {completed[NUM_LAYERS-2:0], handshake};
  assign dec = completed;

  // Sequential mode admits one layer at a time; lowest index wins a tie.
  assign launch = mode_q ? cand
                         : (any_active ? '0 : (cand & (~cand + NUM_LAYERS'(1))));

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      mode_q <= 1'b0;
      for (int unsigned b = 0; b < NUM_LAYERS; b++) begin
        occ[b]    <= OCC_EMPTY;
        wr_ptr[b] <= BANK_A;
        rd_ptr[b] <= BANK_A;
      end
    end else begin
      if (!busy) mode_q <= mode_pipelined;
      for (int unsigned b = 0; b < NUM_LAYERS; b++) begin
        if (inc[b]) wr_ptr[b] <= ~wr_ptr[b];
        if (dec[b]) rd_ptr[b] <= ~rd_ptr[b];
        if (inc[b] && !dec[b])
          occ[b] <= occ[b] + 2'd1;
        else if (dec[b] && !inc[b])
          occ[b] <= occ[b] - 2'd1;
      end
    end
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      result_valid <= 1'b0;
      result_data  <= '0;
      frame_count  <= '0;
    end else if (completed[LAST]) begin
      result_valid <= 1'b1;
      result_data  <= result_code;
      frame_count  <= frame_count + CNT_W'(1);
    end else if (result_ack && result_valid) begin
      result_valid <= 1'b0;
    end
  end

  for (genvar k = 0; k < NUM_LAYERS; k++) begin : g_layer
    logic  out_free;
    bank_t next_wr;

    if (k < NUM_LAYERS - 1) begin : g_mid
      assign out_free = (occ[k+1] < OCC_FULL);
      assign next_wr  = wr_ptr[k+1];
    end else begin : g_last
      assign out_free = !result_valid;
      assign next_wr  = BANK_A;
    end

    assign cand[k] = idle[k] && (occ[k] != OCC_EMPTY) && out_free;

    nn_layer_ctrl #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_ctrl (
      .clk        (clk_clk),
      .rst_n      (reset_reset_n),
      .launch_ok  (launch[k]),
      .layer_done (layer_done[k]),
      .rd_bank    (rd_ptr[k]),
      .wr_bank    (next_wr),
      .ready      (layer_ready[k]),
      .state      (st[k]),
      .completed  (completed[k]),
      .idle       (idle[k]),
      .timed_out  (timeout_err[k]),
      .in_bank    (layer_in_bank[k]),
      .out_bank   (layer_out_bank[k])
    );

    assign layer_state[k*STATE_W +: STATE_W] = STATE_W'(st[k]);
  end

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Directed bench for nn_layer_sequencer: behavioural layer engines respond to
// launch pulses after a programmable delay; expectations are hand-computed.
module tb_nn_layer_sequencer;

  localparam int unsigned NL = 3;
  localparam int unsigned DW = 7;
  localparam int unsigned SW = 4;
  localparam int unsigned TO = 50;
  localparam int unsigned CW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n, mode_pipelined, start_valid, man_ack, auto_ack;
  logic              start_ready, hps_wr_bank, result_valid, busy, result_ack;
  logic [NL-1:0]     layer_ready, layer_done, layer_in_bank, layer_out_bank, timeout_err;
  logic [NL-1:0]     resp_done, man_done, resp_en;
  logic [NL*SW-1:0]  layer_state;
  logic [DW-1:0]     result_code, result_data;
  logic [CW-1:0]     frame_count;

  assign layer_done = resp_done | man_done;
  assign result_ack = man_ack | (auto_ack & result_valid);

  nn_layer_sequencer #(
    .NUM_LAYERS(NL), .DONE_W(DW), .STATE_W(SW), .TIMEOUT_CYCLES(TO), .CNT_W(CW)
  ) dut (
    .clk_clk(clk), .reset_reset_n(rst_n), .mode_pipelined(mode_pipelined),
    .start_valid(start_valid), .start_ready(start_ready), .hps_wr_bank(hps_wr_bank),
    .layer_ready(layer_ready), .layer_done(layer_done), .layer_in_bank(layer_in_bank),
    .layer_out_bank(layer_out_bank), .layer_state(layer_state), .result_code(result_code),
    .result_valid(result_valid), .result_data(result_data), .result_ack(result_ack),
    .timeout_err(timeout_err), .busy(busy), .frame_count(frame_count)
  );

  int unsigned total = 0;
  int unsigned bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural layer engines: done pulse delay[k] cycles after seeing ready.
  int unsigned delay [NL];
  int unsigned cnt   [NL];
  always @(negedge clk) begin
    for (int k = 0; k < NL; k++) begin
      resp_done[k] = 1'b0;
      if (!rst_n || !resp_en[k]) cnt[k] = 0;
      else if (layer_ready[k]) cnt[k] = delay[k];
      else if (cnt[k] > 0) begin
        cnt[k]--;
        if (cnt[k] == 0) resp_done[k] = 1'b1;
      end
    end
  end

  logic       mon_en;
  bit         all_busy;
  logic [7:0] ib1_log;
  int unsigned ib1_n;
  always @(negedge clk) begin
    if (mon_en) begin
      if (layer_state == 12'h222) all_busy = 1'b1;
      if (layer_ready[1]) begin
        ib1_log = {ib1_log[6:0], layer_in_bank[1]};
        ib1_n++;
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start_valid = 1'b0; man_done = '0; man_ack = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic push(input int unsigned budget, output bit ok);
    ok = 1'b0;
    start_valid = 1'b1;
    for (int unsigned i = 0; i < budget && !ok; i++) begin
      if (start_ready) ok = 1'b1;
      step();
    end
    start_valid = 1'b0;
  endtask

  function automatic logic [3:0] st(input int k);
    return layer_state[k*SW +: SW];
  endfunction

  task automatic wait_state(input int k, input logic [3:0] s, input int unsigned budget,
                            input string tag);
    int unsigned i = 0;
    while (st(k) != s && i < budget) begin step(); i++; end
    check(tag, 32'(st(k)), 32'(s));
  endtask

  initial begin
    bit          ok;
    logic [5:0]  ord;
    int unsigned n, sr_bad, acc;
    logic [3:0]  hs;

    rst_n = 1'b0; mode_pipelined = 1'b0; start_valid = 1'b0; man_ack = 1'b0;
    auto_ack = 1'b0; man_done = '0; resp_en = '0; result_code = '0; mon_en = 1'b0;
    all_busy = 1'b0; ib1_log = '0; ib1_n = 0;
    for (int k = 0; k < NL; k++) delay[k] = 10;

    // Sequential, one frame, 10-cycle layers
    resp_en = 3'b111;
    do_reset();
    check("rst_ready",  32'(layer_ready), 0);
    check("rst_state",  32'(layer_state), 0);
    check("rst_valid",  32'(result_valid), 0);
    check("rst_count",  32'(frame_count), 0);
    check("rst_terr",   32'(timeout_err), 0);
    check("rst_busy",   32'(busy), 0);
    check("rst_hpsbank",32'(hps_wr_bank), 0);
    result_code = 7'h05;
    push(5, ok);
    check("seq_push", 32'(ok), 1);
    check("lat_before", 32'(layer_ready), 0);
    step();
    check("lat_launch", 32'(layer_ready), 32'h1);
    ord = 6'b0; n = 1; sr_bad = 0;
    for (int i = 0; i < 200 && !result_valid; i++) begin
      step();
      for (int k = 0; k < NL; k++)
        if (layer_ready[k]) begin ord = {ord[3:0], 2'(k)}; n++; end
      if (busy && start_ready) sr_bad++;
    end
    check("seq_npulse", n, 3);
    check("seq_order", 32'(ord), 32'b00_01_10);
    check("seq_valid", 32'(result_valid), 1);
    check("seq_data", 32'(result_data), 5);
    check("seq_count", 32'(frame_count), 1);
    check("seq_sr_busy", sr_bad, 0);
    repeat (5) step();
    check("seq_sr_held", 32'(start_ready), 0);
    man_ack = 1'b1; step(); man_ack = 1'b0; step();
    check("seq_sr_ack", 32'(start_ready), 1);
    check("seq_idle", 32'(busy), 0);

    // Pipelined, 4 back-to-back frames, instant acks
    mode_pipelined = 1'b1; auto_ack = 1'b1;
    do_reset();
    mon_en = 1'b1; all_busy = 1'b0; ib1_log = '0; ib1_n = 0; hs = '0; acc = 0;
    for (int f = 0; f < 4; f++) begin
      hs = {hs[2:0], hps_wr_bank};
      push(100, ok);
      if (ok) acc++;
    end
    check("pipe_accept", acc, 4);
    for (int i = 0; i < 300 && frame_count != 4; i++) step();
    check("pipe_count", 32'(frame_count), 4);
    check("pipe_hpsbank", 32'(hs), 32'b0101);
    check("pipe_allbusy", 32'(all_busy), 1);
    check("pipe_ib1_n", ib1_n, 4);
    check("pipe_ib1_seq", 32'(ib1_log[3:0]), 32'b0101);
    mon_en = 1'b0; auto_ack = 1'b0;

    // Pipelined, result never acked: chain fills to 7 frames
    for (int k = 0; k < NL; k++) delay[k] = 3;
    result_code = 7'h2A;
    do_reset();
    acc = 0;
    for (int f = 0; f < 8; f++) begin
      push(40, ok);
      if (ok) acc++;
    end
    repeat (20) step();
    check("stall_accept", acc, 7);
    check("stall_sr", 32'(start_ready), 0);
    check("stall_occ0", 32'(dut.occ[0]), 2);
    check("stall_occ1", 32'(dut.occ[1]), 2);
    check("stall_occ2", 32'(dut.occ[2]), 2);
    check("stall_state", 32'(layer_state), 0);
    check("stall_count", 32'(frame_count), 1);
    check("stall_data", 32'(result_data), 32'h2A);
    man_ack = 1'b1; step(); man_ack = 1'b0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (layer_ready[2]) n++;
      step();
    end
    check("stall_l2_launch", n, 1);
    check("stall_count2", 32'(frame_count), 2);
    check("stall_valid2", 32'(result_valid), 1);

    // Timeout: layer 1 never completes
    mode_pipelined = 1'b0; resp_en = 3'b101;
    do_reset();
    push(5, ok);
    wait_state(1, 4'd2, 60, "to_enter_busy");
    repeat (TO - 1) step();
    check("to_last_busy", 32'(st(1)), 2);
    check("to_err_early", 32'(timeout_err), 0);
    step();
    check("to_state", 32'(st(1)), 4);
    check("to_err", 32'(timeout_err), 32'b010);
    man_done[1] = 1'b1; step(); man_done = '0;
    repeat (5) step();
    check("to_frozen", 32'(st(1)), 4);
    check("to_l2_idle", 32'(st(2)), 0);
    check("to_count", 32'(frame_count), 0);
    do_reset();
    check("to_rst_err", 32'(timeout_err), 0);
    check("to_rst_state", 32'(layer_state), 0);

    // Same-cycle start handshake and layer-0 done with occ[0]=1
    mode_pipelined = 1'b1; resp_en = 3'b110; auto_ack = 1'b1;
    do_reset();
    push(5, ok);
    wait_state(0, 4'd2, 10, "sim_busy");
    check("sim_wrbank_pre", 32'(hps_wr_bank), 1);
    check("sim_sr", 32'(start_ready), 1);
    start_valid = 1'b1; man_done[0] = 1'b1;
    step();
    start_valid = 1'b0; man_done = '0;
    check("sim_occ0", 32'(dut.occ[0]), 1);
    check("sim_wrbank", 32'(hps_wr_bank), 0);
    n = 0;
    while (!layer_ready[0] && n < 10) begin step(); n++; end
    check("sim_relaunch", 32'(layer_ready[0]), 1);
    check("sim_inbank", 32'(layer_in_bank[0]), 1);
    check("sim_outbank", 32'(layer_out_bank[0]), 1);
    auto_ack = 1'b0;

    // Reset mid-frame with layer 2 busy
    mode_pipelined = 1'b0; resp_en = 3'b011;
    do_reset();
    push(5, ok);
    wait_state(2, 4'd2, 60, "mid_l2_busy");
    rst_n = 1'b0;
    step();
    check("mid_state", 32'(layer_state), 0);
    check("mid_ready", 32'(layer_ready), 0);
    check("mid_busy", 32'(busy), 0);
    check("mid_hpsbank", 32'(hps_wr_bank), 0);
    check("mid_banks", 32'({layer_in_bank, layer_out_bank}), 0);
    rst_n = 1'b1;
    step();
    man_done[2] = 1'b1; step(); man_done = '0;
    repeat (3) step();
    check("mid_stale_valid", 32'(result_valid), 0);
    check("mid_stale_count", 32'(frame_count), 0);
    check("mid_stale_state", 32'(layer_state), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
